// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Package : exc_pkg
// Brief   : ExcCodes, CP0 register numbers, sequencer states, default vector.
// Rev     : 1.0
// ============================================================================
package exc_pkg;

    localparam logic [4:0] C_EXC_INT  = 5'h00;
    localparam logic [4:0] C_EXC_ADEL = 5'h04;
    localparam logic [4:0] C_EXC_ADES = 5'h05;
    localparam logic [4:0] C_EXC_SYS  = 5'h08;
    localparam logic [4:0] C_EXC_BP   = 5'h09;
    localparam logic [4:0] C_EXC_RI   = 5'h0a;
    localparam logic [4:0] C_EXC_OV   = 5'h0c;

    localparam logic [4:0] C_CP0_BADVADDR = 5'd8;
    localparam logic [4:0] C_CP0_STATUS   = 5'd12;
    localparam logic [4:0] C_CP0_CAUSE    = 5'd13;
    localparam logic [4:0] C_CP0_EPC      = 5'd14;

    localparam logic [31:0] C_EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Bit positions inside exc_flags = {eret, ades, adel_d, brk, sys, ov, ri}
    localparam int C_FLAG_RI   = 0;
    localparam int C_FLAG_OV   = 1;
    localparam int C_FLAG_SYS  = 2;
    localparam int C_FLAG_BRK  = 3;
    localparam int C_FLAG_ADEL = 4;
    localparam int C_FLAG_ADES = 5;
    localparam int C_FLAG_ERET = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_EPC   = 3'd1,
        ST_W_BADV  = 3'd2,
        ST_W_STAT  = 3'd3,
        ST_W_CAUSE = 3'd4,
        ST_REDIR   = 3'd5
    } exc_state_t;

    typedef struct packed {
        logic       take;
        logic       is_eret;
        logic [4:0] code;
        logic       use_badv;
        logic       badv_from_pc;
    } exc_prio_t;

endpackage
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module : exc_prio_enc
// Brief  : Combinational priority encoder: interrupt/flags -> take, ERET, code.
// Rev    : 1.0
// ============================================================================
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_pending,
    input  logic       adel_if,
    input  logic [6:0] flags,
    output exc_prio_t  prio
);

    always_comb begin
        prio      = '0;
        prio.take = 1'b1;
        if (int_pending) begin
            prio.code = C_EXC_INT;
        end else if (adel_if) begin
            prio.code         = C_EXC_ADEL;
            prio.use_badv     = 1'b1;
            prio.badv_from_pc = 1'b1;
        end else if (flags[C_FLAG_RI]) begin
            prio.code = C_EXC_RI;
        end else if (flags[C_FLAG_OV]) begin
            prio.code = C_EXC_OV;
        end else if (flags[C_FLAG_SYS]) begin
            prio.code = C_EXC_SYS;
        end else if (flags[C_FLAG_BRK]) begin
            prio.code = C_EXC_BP;
        end else if (flags[C_FLAG_ADEL]) begin
            prio.code     = C_EXC_ADEL;
            prio.use_badv = 1'b1;
        end else if (flags[C_FLAG_ADES]) begin
            prio.code     = C_EXC_ADES;
            prio.use_badv = 1'b1;
        end else if (flags[C_FLAG_ERET]) begin
            prio.is_eret = 1'b1;
        end else begin
            prio.take = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module : exception_ctrl
// Brief  : Precise-exception / ERET sequencer: one CP0 write per cycle, then
//          flush + fetch redirect. EXC_STATS_EN adds the exc_count port.
// Rev    : 1.0
// ============================================================================
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(C_EXC_VECTOR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic [WIDTH-1:0] exc_badaddr,
    input  logic             exc_in_delay,
    input  logic [6:0]       exc_flags,
    input  logic             exc_adel_if,
    input  logic [WIDTH-1:0] status_data,
    input  logic [WIDTH-1:0] epc_data,
    input  logic [5:0]       hw_int,
    input  logic [1:0]       sw_int,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badaddr,
    output logic [4:0]       cp0_exc_code,
    output logic             cp0_bd,
    output logic             cp0_exl,
    output logic             cp0_ie,
    output logic [7:0]       cp0_int_mask,
    output logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
`ifdef EXC_STATS_EN
    ,
    output logic [WIDTH-1:0] exc_count
`endif
);

    exc_state_t       r_state;
    exc_state_t       w_nxt_state;
    exc_prio_t        w_prio;
    logic             w_int_pending;
    logic             w_detect;
    logic             w_unused_status;

    logic [WIDTH-1:0] r_epc,      w_cur_epc;
    logic [WIDTH-1:0] r_badv,     w_cur_badv;
    logic [4:0]       r_code,     w_cur_code;
    logic [7:0]       r_im,       w_cur_im;
    logic             r_bd,       w_cur_bd;
    logic             r_use_badv, w_cur_use_badv;
    logic             r_is_eret,  w_cur_is_eret;
    logic             r_ie,       w_cur_ie;

    assign w_unused_status = ^{status_data[WIDTH-1:16], status_data[7:2]};

    assign w_int_pending = status_data[0] & ~status_data[1]
                         & (|({hw_int, sw_int} & status_data[15:8]));

    exc_prio_enc u_prio (
        .int_pending (w_int_pending),
        .adel_if     (exc_adel_if),
        .flags       (exc_flags),
        .prio        (w_prio)
    );

    assign w_detect = (r_state == ST_IDLE) && exc_valid && w_prio.take;

    // Context visible to the output decode: fresh inputs on the detect edge, latched otherwise
    always_comb begin
        w_cur_epc      = r_epc;
        w_cur_badv     = r_badv;
        w_cur_code     = r_code;
        w_cur_im       = r_im;
        w_cur_bd       = r_bd;
        w_cur_use_badv = r_use_badv;
        w_cur_is_eret  = r_is_eret;
        w_cur_ie       = r_ie;
        if (w_detect) begin
            w_cur_epc      = exc_in_delay ? (exc_pc - WIDTH'(4)) : exc_pc;
            w_cur_badv     = w_prio.badv_from_pc ? exc_pc : exc_badaddr;
            w_cur_code     = w_prio.code;
            w_cur_im       = status_data[15:8];
            w_cur_bd       = exc_in_delay;
            w_cur_use_badv = w_prio.use_badv;
            w_cur_is_eret  = w_prio.is_eret;
            w_cur_ie       = status_data[0];
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_detect) begin
                    if (w_prio.is_eret)
                        w_nxt_state = ST_W_STAT;
                    else if (!status_data[1])
                        w_nxt_state = ST_W_EPC;
                    else if (w_prio.use_badv)
                        w_nxt_state = ST_W_BADV;
                    else
                        w_nxt_state = ST_W_STAT;
                end
            end
            ST_W_EPC:   w_nxt_state = r_use_badv ? ST_W_BADV : ST_W_STAT;
            ST_W_BADV:  w_nxt_state = ST_W_STAT;
            ST_W_STAT:  w_nxt_state = r_is_eret ? ST_REDIR : ST_W_CAUSE;
            ST_W_CAUSE: w_nxt_state = ST_REDIR;
            ST_REDIR:   w_nxt_state = ST_IDLE;
            default:    w_nxt_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_epc          <= '0;
            r_badv         <= '0;
            r_code         <= '0;
            r_im           <= '0;
            r_bd           <= 1'b0;
            r_use_badv     <= 1'b0;
            r_is_eret      <= 1'b0;
            r_ie           <= 1'b0;
            cp0_we         <= 1'b0;
            cp0_waddr      <= '0;
            cp0_epc        <= '0;
            cp0_badaddr    <= '0;
            cp0_exc_code   <= '0;
            cp0_bd         <= 1'b0;
            cp0_exl        <= 1'b0;
            cp0_ie         <= 1'b0;
            cp0_int_mask   <= '0;
            stall          <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_epc          <= w_cur_epc;
            r_badv         <= w_cur_badv;
            r_code         <= w_cur_code;
            r_im           <= w_cur_im;
            r_bd           <= w_cur_bd;
            r_use_badv     <= w_cur_use_badv;
            r_is_eret      <= w_cur_is_eret;
            r_ie           <= w_cur_ie;

            cp0_we         <= 1'b0;
            cp0_waddr      <= '0;
            cp0_epc        <= '0;
            cp0_badaddr    <= '0;
            cp0_exc_code   <= '0;
            cp0_bd         <= 1'b0;
            cp0_exl        <= 1'b0;
            cp0_ie         <= 1'b0;
            cp0_int_mask   <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall          <= (w_nxt_state != ST_IDLE);

            case (w_nxt_state)
                ST_W_EPC: begin
                    cp0_we    <= 1'b1;
                    cp0_waddr <= C_CP0_EPC;
                    cp0_epc   <= w_cur_epc;
                end
                ST_W_BADV: begin
                    cp0_we      <= 1'b1;
                    cp0_waddr   <= C_CP0_BADVADDR;
                    cp0_badaddr <= w_cur_badv;
                end
                ST_W_STAT: begin
                    cp0_we       <= 1'b1;
                    cp0_waddr    <= C_CP0_STATUS;
                    cp0_exl      <= ~w_cur_is_eret;
                    cp0_ie       <= w_cur_ie;
                    cp0_int_mask <= w_cur_im;
                end
                ST_W_CAUSE: begin
                    cp0_we       <= 1'b1;
                    cp0_waddr    <= C_CP0_CAUSE;
                    cp0_exc_code <= w_cur_code;
                    cp0_bd       <= w_cur_bd;
                end
                ST_REDIR: begin
                    flush          <= 1'b1;
                    redirect_valid <= 1'b1;
                    // ERET target is the EPC value seen while Status is being written
                    redirect_pc    <= r_is_eret ? epc_data : EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end

`ifdef EXC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            exc_count <= '0;
        else if (w_detect && !w_prio.is_eret && (exc_count != {WIDTH{1'b1}}))
            exc_count <= exc_count + WIDTH'(1);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_exception_ctrl
// Brief  : Self-checking bench for exception_ctrl: directed table, reset abort,
//          randomized transactions against a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [31:0] exc_pc, exc_badaddr, status_data, epc_data;
    logic        exc_in_delay, exc_adel_if;
    logic [6:0]  exc_flags;
    logic [5:0]  hw_int;
    logic [1:0]  sw_int;
    logic        cp0_we, cp0_bd, cp0_exl, cp0_ie, stall, flush, redirect_valid;
    logic [4:0]  cp0_waddr, cp0_exc_code;
    logic [31:0] cp0_epc, cp0_badaddr, redirect_pc;
    logic [7:0]  cp0_int_mask;
`ifdef EXC_STATS_EN
    logic [31:0] exc_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    exception_ctrl #(.WIDTH(32), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_badaddr(exc_badaddr), .exc_in_delay(exc_in_delay), .exc_flags(exc_flags),
        .exc_adel_if(exc_adel_if), .status_data(status_data), .epc_data(epc_data),
        .hw_int(hw_int), .sw_int(sw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_epc(cp0_epc), .cp0_badaddr(cp0_badaddr), .cp0_exc_code(cp0_exc_code),
        .cp0_bd(cp0_bd), .cp0_exl(cp0_exl), .cp0_ie(cp0_ie), .cp0_int_mask(cp0_int_mask),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
`ifdef EXC_STATS_EN
        , .exc_count(exc_count)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic        in_delay;
        logic [6:0]  flags;
        logic        adel_if;
        logic [31:0] status;
        logic [31:0] epc_data;
        logic [5:0]  hw;
        logic [1:0]  sw;
        logic [5:0]  late_hw;
    } vec_t;

    typedef struct {
        logic        took;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
        logic [19:0] seq;
        logic [31:0] rpc;
        logic [31:0] lat;
        logic        exl;
        logic        ie;
        logic [7:0]  im;
        logic        stall_ok;
        logic        flush_ok;
        logic        idle_ok;
    } res_t;

    typedef struct {
        vec_t v;
        res_t e;
    } tv_t;

    function automatic vec_t mkv(logic valid, logic [31:0] pc, logic [31:0] badaddr,
                                 logic in_delay, logic [6:0] flags, logic adel_if,
                                 logic [31:0] status, logic [31:0] epcd, logic [5:0] hw,
                                 logic [1:0] sw, logic [5:0] late_hw);
        vec_t v;
        v.valid = valid; v.pc = pc; v.badaddr = badaddr; v.in_delay = in_delay;
        v.flags = flags; v.adel_if = adel_if; v.status = status; v.epc_data = epcd;
        v.hw = hw; v.sw = sw; v.late_hw = late_hw;
        return v;
    endfunction

    function automatic res_t mke(logic took, logic [4:0] code, logic [31:0] epc, logic bd,
                                 logic [31:0] badv, logic [19:0] seq, logic [31:0] rpc,
                                 logic [31:0] lat);
        res_t r;
        r = '{default: '0};
        r.took = took; r.code = code; r.epc = epc; r.bd = bd; r.badv = badv;
        r.seq = seq; r.rpc = rpc; r.lat = lat;
        r.stall_ok = 1'b1; r.flush_ok = 1'b1; r.idle_ok = 1'b1;
        return r;
    endfunction

    // Reference: list of CP0 writes a transaction must produce, derived from the rules
    function automatic res_t model(input vec_t v);
        res_t        r;
        logic [7:0]  ip;
        logic        intp;
        logic        badv_kind;
        logic [31:0] n;
        r = '{default: '0};
        r.stall_ok = 1'b1; r.flush_ok = 1'b1; r.idle_ok = 1'b1;
        if (!v.valid) return r;
        ip = {v.hw, v.sw} & v.status[15:8];
        intp = v.status[0] && !v.status[1] && (ip != 8'd0);
        badv_kind = 1'b0;
        if (intp)               r.code = 5'h00;
        else if (v.adel_if)   begin r.code = 5'h04; badv_kind = 1'b1; r.badv = v.pc; end
        else if (v.flags[0])    r.code = 5'h0a;
        else if (v.flags[1])    r.code = 5'h0c;
        else if (v.flags[2])    r.code = 5'h08;
        else if (v.flags[3])    r.code = 5'h09;
        else if (v.flags[4])  begin r.code = 5'h04; badv_kind = 1'b1; r.badv = v.badaddr; end
        else if (v.flags[5])  begin r.code = 5'h05; badv_kind = 1'b1; r.badv = v.badaddr; end
        else if (v.flags[6]) begin
            r.took = 1'b1; r.seq = {15'd0, 5'd12}; r.exl = 1'b0;
            r.ie = v.status[0]; r.im = v.status[15:8]; r.rpc = v.epc_data; r.lat = 32'd2;
            return r;
        end else return r;
        r.took = 1'b1; r.bd = v.in_delay; r.rpc = VEC; n = 32'd0;
        if (!v.status[1]) begin
            r.epc = v.in_delay ? v.pc - 32'd4 : v.pc;
            r.seq = {r.seq[14:0], 5'd14}; n = n + 32'd1;
        end
        if (badv_kind) begin r.seq = {r.seq[14:0], 5'd8}; n = n + 32'd1; end
        r.seq = {r.seq[9:0], 5'd12, 5'd13};
        r.exl = 1'b1; r.ie = v.status[0]; r.im = v.status[15:8];
        r.lat = n + 32'd3;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; exc_pc = '0; exc_badaddr = '0; exc_in_delay = 1'b0;
        exc_flags = '0; exc_adel_if = 1'b0; status_data = '0; epc_data = '0;
        hw_int = '0; sw_int = '0;
    endtask

    task automatic apply(input vec_t v, output res_t r);
        r = '{default: '0};
        r.stall_ok = 1'b1; r.flush_ok = 1'b1;
        @(negedge clk);
        exc_valid = v.valid; exc_pc = v.pc; exc_badaddr = v.badaddr;
        exc_in_delay = v.in_delay; exc_flags = v.flags; exc_adel_if = v.adel_if;
        status_data = v.status; epc_data = v.epc_data; hw_int = v.hw; sw_int = v.sw;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1 && v.late_hw != 6'd0) hw_int = v.late_hw;
            if (flush !== redirect_valid) r.flush_ok = 1'b0;
            if (cp0_we) begin
                r.seq = {r.seq[14:0], cp0_waddr};
                case (cp0_waddr)
                    5'd14: r.epc = cp0_epc;
                    5'd8:  r.badv = cp0_badaddr;
                    5'd12: begin r.exl = cp0_exl; r.ie = cp0_ie; r.im = cp0_int_mask; end
                    5'd13: begin r.code = cp0_exc_code; r.bd = cp0_bd; end
                    default: ;
                endcase
            end
            if (c == 1 && !stall) break;
            if (!stall) r.stall_ok = 1'b0;
            if (redirect_valid) begin
                r.took = 1'b1; r.lat = 32'(c); r.rpc = redirect_pc;
                break;
            end
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        r.idle_ok = !stall && !cp0_we && !redirect_valid && !flush;
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e, input bit full);
        cmp({tag, ".took"},  32'(a.took),     32'(e.took));
        cmp({tag, ".code"},  32'(a.code),     32'(e.code));
        cmp({tag, ".epc"},   a.epc,           e.epc);
        cmp({tag, ".bd"},    32'(a.bd),       32'(e.bd));
        cmp({tag, ".badv"},  a.badv,          e.badv);
        cmp({tag, ".wseq"},  32'(a.seq),      32'(e.seq));
        cmp({tag, ".rpc"},   a.rpc,           e.rpc);
        cmp({tag, ".lat"},   a.lat,           e.lat);
        cmp({tag, ".stall"}, 32'(a.stall_ok), 32'(e.stall_ok));
        cmp({tag, ".flush"}, 32'(a.flush_ok), 32'(e.flush_ok));
        cmp({tag, ".idle"},  32'(a.idle_ok),  32'(e.idle_ok));
        if (full) begin
            cmp({tag, ".exl"}, 32'(a.exl), 32'(e.exl));
            cmp({tag, ".ie"},  32'(a.ie),  32'(e.ie));
            cmp({tag, ".im"},  32'(a.im),  32'(e.im));
        end
    endtask

    initial begin
        tv_t  tbl [13];
        res_t a, e;
        vec_t v;
        logic saw;

        tbl[0].v  = mkv(1, 32'h80001000, 0, 0, 7'b0000010, 0, 32'h0, 0, 0, 0, 0);
        tbl[0].e  = mke(1, 5'h0c, 32'h80001000, 0, 0, {5'd0, 5'd14, 5'd12, 5'd13}, VEC, 4);
        tbl[1].v  = mkv(1, 32'h80002004, 32'h80000003, 1, 7'b0010000, 0, 32'h0, 0, 0, 0, 0);
        tbl[1].e  = mke(1, 5'h04, 32'h80002000, 1, 32'h80000003, {5'd14, 5'd8, 5'd12, 5'd13}, VEC, 5);
        tbl[2].v  = mkv(1, 32'h80003000, 0, 0, 7'b0000100, 0, 32'h00000401, 0, 6'b000001, 0, 0);
        tbl[2].e  = mke(1, 5'h00, 32'h80003000, 0, 0, {5'd0, 5'd14, 5'd12, 5'd13}, VEC, 4);
        tbl[3].v  = mkv(1, 32'h80003000, 0, 0, 7'b0000100, 0, 32'h00000403, 0, 6'b000001, 0, 0);
        tbl[3].e  = mke(1, 5'h08, 0, 0, 0, {10'd0, 5'd12, 5'd13}, VEC, 3);
        tbl[4].v  = mkv(1, 32'h80004000, 0, 0, 7'b1000000, 0, 32'h00000003, 32'h80000100, 0, 0, 0);
        tbl[4].e  = mke(1, 5'h00, 0, 0, 0, {15'd0, 5'd12}, 32'h80000100, 2);
        tbl[5].v  = mkv(0, 32'h80005000, 0, 0, 7'b0000001, 0, 32'h0, 0, 0, 0, 0);
        tbl[5].e  = mke(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6].v  = mkv(1, 32'h80005000, 0, 0, 7'b0000000, 0, 32'h0, 0, 0, 0, 0);
        tbl[6].e  = mke(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7].v  = mkv(1, 32'h80004001, 32'hDEAD0000, 0, 7'b0000011, 1, 32'h0, 0, 0, 0, 0);
        tbl[7].e  = mke(1, 5'h04, 32'h80004001, 0, 32'h80004001, {5'd14, 5'd8, 5'd12, 5'd13}, VEC, 5);
        tbl[8].v  = mkv(1, 32'h00000000, 32'h12345678, 1, 7'b0100000, 0, 32'h0, 0, 0, 0, 0);
        tbl[8].e  = mke(1, 5'h05, 32'hFFFFFFFC, 1, 32'h12345678, {5'd14, 5'd8, 5'd12, 5'd13}, VEC, 5);
        tbl[9].v  = mkv(1, 32'h80006000, 32'h00000011, 0, 7'b0011000, 0, 32'h0, 0, 0, 0, 0);
        tbl[9].e  = mke(1, 5'h09, 32'h80006000, 0, 0, {5'd0, 5'd14, 5'd12, 5'd13}, VEC, 4);
        tbl[10].v = mkv(1, 32'h80006000, 0, 0, 7'b0000000, 0, 32'h00000001, 0, 6'h3f, 2'b11, 0);
        tbl[10].e = mke(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11].v = mkv(1, 32'h80007000, 0, 1, 7'b0000001, 0, 32'h00000201, 0, 0, 2'b10, 0);
        tbl[11].e = mke(1, 5'h00, 32'h80006FFC, 1, 0, {5'd0, 5'd14, 5'd12, 5'd13}, VEC, 4);
        tbl[12].v = mkv(1, 32'h80008000, 0, 0, 7'b0000100, 0, 32'h00000401, 0, 0, 0, 6'b000001);
        tbl[12].e = mke(1, 5'h08, 32'h80008000, 0, 0, {5'd0, 5'd14, 5'd12, 5'd13}, VEC, 4);

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset.we",       32'(cp0_we),         32'd0);
        cmp("reset.waddr",    32'(cp0_waddr),      32'd0);
        cmp("reset.stall",    32'(stall),          32'd0);
        cmp("reset.flush",    32'(flush),          32'd0);
        cmp("reset.redirect", 32'(redirect_valid), 32'd0);
        cmp("reset.rpc",      redirect_pc,         32'd0);
`ifdef EXC_STATS_EN
        cmp("reset.count",    exc_count,           32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].v, a);
            check_res($sformatf("tbl%0d", i), a, tbl[i].e, 1'b0);
            e = model(tbl[i].v);
            if (e.took && e.exl) exp_cnt++;
        end

        // Reset while the Status write is in flight: sequence must stop dead
        @(negedge clk);
        exc_valid = 1'b1; exc_flags = 7'b0000001; exc_pc = 32'h80005000; status_data = '0;
        @(posedge clk); #1;
        cmp("abort.epc_write",  32'({cp0_we, cp0_waddr}), 32'({1'b1, 5'd14}));
        @(posedge clk); #1;
        cmp("abort.stat_write", 32'({cp0_we, cp0_waddr}), 32'({1'b1, 5'd12}));
        #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        cmp("abort.outputs", 32'({cp0_we, stall, flush, redirect_valid, cp0_waddr}), 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (cp0_we || stall || redirect_valid) saw = 1'b1;
        end
        cmp("abort.quiet", 32'(saw), 32'd0);
`ifdef EXC_STATS_EN
        cmp("abort.count", exc_count, 32'd0);
`endif
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        v = mkv(1, 32'h80005000, 0, 0, 7'b0000001, 0, 32'h00000001, 0, 0, 0, 0);
        apply(v, a);
        e = model(v);
        check_res("after_abort", a, e, 1'b1);
        if (e.took && e.exl) exp_cnt++;

        for (int i = 0; i < 40; i++) begin
            v.valid    = ($urandom_range(0, 9) != 0);
            v.pc       = $urandom;
            v.badaddr  = $urandom;
            v.in_delay = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v.flags = 7'd0;
                1, 2:    v.flags = 7'(1 << $urandom_range(0, 6));
                default: v.flags = 7'($urandom);
            endcase
            v.adel_if  = ($urandom_range(0, 7) == 0);
            v.status   = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            v.epc_data = $urandom;
            v.hw       = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            v.sw       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            v.late_hw  = 6'($urandom);
            apply(v, a);
            e = model(v);
            check_res($sformatf("rnd%0d", i), a, e, 1'b1);
            if (e.took && e.exl) exp_cnt++;
        end

`ifdef EXC_STATS_EN
        cmp("stats.count", exc_count, 32'(exp_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
